// File: rtl/pulse_timer.sv
// pulse_timer: programmable period tick generator with periodic and one-shot
// modes. A period register P and counter Q (Q < P) produce a single-cycle
// Pulse every P enabled edges; Ticks counts emitted pulses modulo 256.
module pulse_timer #(
  parameter int WIDTH       = 26,
  parameter int DEFAULT_DIV = 50_000_000
) (
  input  logic             Clk,
  input  logic             Resetn,
  input  logic             En,
  input  logic             Mode,
  input  logic             Start,
  input  logic             Load,
  input  logic [WIDTH-1:0] Div,
  output logic             Pulse,
  output logic             Busy,
  output logic [WIDTH-1:0] Count,
  output logic [7:0]       Ticks
);

  localparam logic [WIDTH-1:0] DEF_PERIOD = DEFAULT_DIV[WIDTH-1:0];
  localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO       = {WIDTH{1'b0}};

  typedef enum logic [1:0] {
    FREE = 2'd0,
    IDLE = 2'd1,
    SHOT = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] q;
  logic             mode_q;
  logic             pulse_r;
  logic             busy_r;
  logic [7:0]       ticks_r;

  // High when the counter is at its last value and the next enabled edge wraps.
  logic last_s;
  assign last_s = (q == (period - ONE));

  // Timer FSM: reset, then Load, then Mode change, then counting, in that priority.
  always_ff @(posedge Clk) begin
    mode_q <= Mode;
    if (!Resetn) begin
      period  <= DEF_PERIOD;
      q       <= ZERO;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      ticks_r <= 8'd0;
      state   <= Mode ? IDLE : FREE;
    end else if (Load && (Div != ZERO)) begin
      // A zero divisor would break Q < P, so such a Load falls through as if absent.
      period  <= Div;
      q       <= ZERO;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      state   <= Mode ? IDLE : FREE;
    end else if (Mode != mode_q) begin
      q       <= ZERO;
      pulse_r <= 1'b0;
      busy_r  <= 1'b0;
      state   <= Mode ? IDLE : FREE;
    end else begin
      pulse_r <= 1'b0;
      if (En) begin
        case (state)
          FREE: begin
            if (last_s) begin
              q       <= ZERO;
              pulse_r <= 1'b1;
              ticks_r <= ticks_r + 8'd1;
            end else begin
              q <= q + ONE;
            end
          end
          IDLE: begin
            if (Start) begin
              q      <= ZERO;
              busy_r <= 1'b1;
              state  <= SHOT;
            end else begin
              q <= ZERO;
            end
          end
          SHOT: begin
            // Start is deliberately not examined here: no retrigger.
            if (last_s) begin
              q       <= ZERO;
              pulse_r <= 1'b1;
              ticks_r <= ticks_r + 8'd1;
              busy_r  <= 1'b0;
              state   <= IDLE;
            end else begin
              q <= q + ONE;
            end
          end
          default: begin
            q      <= ZERO;
            busy_r <= 1'b0;
            state  <= Mode ? IDLE : FREE;
          end
        endcase
      end else begin
        q <= q;
      end
    end
  end

  assign Pulse = pulse_r;
  assign Busy  = busy_r;
  assign Count = q;
  assign Ticks = ticks_r;

endmodule

// File: tb/tb_pulse_timer.sv
// Directed testbench for pulse_timer (WIDTH=4, DEFAULT_DIV=5). The driver
// pushes the hand-computed expected outputs for each edge into a scoreboard
// queue; an independent monitor pops and compares after every rising edge.
module tb_pulse_timer;

  logic       Clk = 1'b0;
  logic       Resetn = 1'b0;
  logic       En = 1'b0;
  logic       Mode = 1'b0;
  logic       Start = 1'b0;
  logic       Load = 1'b0;
  logic [3:0] Div = 4'd0;
  logic       Pulse;
  logic       Busy;
  logic [3:0] Count;
  logic [7:0] Ticks;

  typedef struct packed {
    logic       pulse;
    logic       busy;
    logic [3:0] cnt;
    logic [7:0] tk;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  bit   done     = 1'b0;

  pulse_timer #(.WIDTH(4), .DEFAULT_DIV(5)) dut (
    .Clk(Clk), .Resetn(Resetn), .En(En), .Mode(Mode), .Start(Start),
    .Load(Load), .Div(Div), .Pulse(Pulse), .Busy(Busy), .Count(Count),
    .Ticks(Ticks)
  );

  always #5 Clk = ~Clk;

  // Monitor: after each rising edge compare DUT outputs to the next expectation.
  always @(posedge Clk) begin
    exp_t e;
    exp_t got;
    #1;
    if (sb.size() > 0) begin
      e   = sb.pop_front();
      got = '{pulse: Pulse, busy: Busy, cnt: Count, tk: Ticks};
      n_assert++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t: got pulse=%0b busy=%0b count=%0d ticks=%0d, expected pulse=%0b busy=%0b count=%0d ticks=%0d",
                 $time, got.pulse, got.busy, got.cnt, got.tk, e.pulse, e.busy, e.cnt, e.tk);
      end
    end
  end

  // Drive one edge worth of inputs and queue the expected post-edge outputs.
  task automatic step(input logic rn, input logic en, input logic md,
                      input logic st, input logic ld, input logic [3:0] dv,
                      input logic ep, input logic eb, input logic [3:0] ec,
                      input logic [7:0] et);
    @(negedge Clk);
    Resetn = rn; En = en; Mode = md; Start = st; Load = ld; Div = dv;
    sb.push_back('{pulse: ep, busy: eb, cnt: ec, tk: et});
  endtask

  initial begin
    // Reset in periodic mode.
    step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd7, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Periodic, P=5: pulses on enabled edges 5, 10, 15, 20.
    for (int i = 1; i <= 20; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, (i % 5) == 0, 1'b0,
           4'(i % 5), 8'(i / 5));

    // Gating: reach Q=2, hold with En=0, then finish the period.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd1, 8'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 8'd4);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 8'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd3, 8'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd4, 8'd4);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 8'd5);

    // Load Div=3 at Q=4.
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'(i), 8'd5);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd3, 1'b0, 1'b0, 4'd0, 8'd5);
    for (int i = 1; i <= 6; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, (i % 3) == 0, 1'b0,
           4'(i % 3), 8'(5 + i / 3));
    // Load Div=0 is ignored: counting continues with P=3.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0, 1'b0, 4'd1, 8'd7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd2, 8'd7);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 8'd8);
    // Load Div=1: Pulse on every enabled edge.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 8'd8);
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 8'(8 + i));
    // Reload P=5 in periodic mode.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd5, 1'b0, 1'b0, 4'd0, 8'd12);

    // Mode change to one-shot: Start on the same edge is ignored.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd12);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd12);
    // Start with En=0 is ignored.
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd12);
    // Start with En=1 arms SHOT.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 8'd12);
    for (int i = 1; i <= 4; i++)
      step(1'b1, 1'b1, 1'b1, (i == 2), 1'b0, 4'd0, 1'b0, 1'b1, 4'(i), 8'd12);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 8'd13);
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd13);

    // Abort: reset at Q=3 during SHOT.
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 1'b0, 1'b1, 4'd0, 8'd13);
    for (int i = 1; i <= 3; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b1, 4'(i), 8'd13);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 0; i < 6; i++)
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 8'd0);

    // Wrap: Load P=1 in periodic mode, 256 pulses bring Ticks back to 0.
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 1'b0, 1'b0, 4'd0, 8'd0);
    for (int i = 1; i <= 256; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 1'b1, 1'b0, 4'd0, 8'(i % 256));

    @(negedge Clk);
    @(negedge Clk);
    n_assert++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // Watchdog: the run must never hang.
  initial begin
    #200000;
    if (!done) begin
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog expired");
    end
  end

endmodule
